// File: rtl/adc_pkg.sv
// Shared constants and helpers for the ADC streaming path.
// Lane index is sized for the widest legal pack (4 samples per beat).
package adc_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_LEN_WIDTH  = 16;
    localparam int MAX_SPB         = 4;

    typedef logic [1:0] lane_idx_t;

    function automatic bit spb_legal(input int spb);
        return (spb == 1) || (spb == 2) || (spb == 4);
    endfunction

endpackage

// File: rtl/adc_stream_beat_reg.sv
// Single-entry AXI-Stream output register. A new beat may only be loaded
// when the slot is empty or draining, so a presented beat never changes.
module adc_stream_beat_reg #(
    parameter int WIDTH = 64
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             tready,
    output logic             tvalid,
    output logic [WIDTH-1:0] tdata,
    output logic             tlast
);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_stream_packer.sv
// Packs SAMPLES_PER_BEAT narrow ADC samples into one wide AXI-Stream beat,
// framing packets every packet_len beats or on an explicit flush.
module adc_stream_packer
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH       = AXIS_DATA_WIDTH,
    parameter int SAMPLES_PER_BEAT = 2,
    parameter int LEN_WIDTH        = AXIS_LEN_WIDTH
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  enable,
    input  logic [LEN_WIDTH-1:0]                  packet_len,
    input  logic                                  flush,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic [DATA_WIDTH*SAMPLES_PER_BEAT-1:0] m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [31:0]                           packet_count
);

    localparam lane_idx_t LAST_LANE = lane_idx_t'(SAMPLES_PER_BEAT - 1);

    generate
        if (!spb_legal(SAMPLES_PER_BEAT)) begin : g_bad_spb
            $error("adc_stream_packer: SAMPLES_PER_BEAT must be 1, 2 or 4");
        end
    endgenerate

    lane_idx_t                                  lane_idx;
    logic [SAMPLES_PER_BEAT-1:0][DATA_WIDTH-1:0] pack_buf;
    logic [SAMPLES_PER_BEAT-1:0][DATA_WIDTH-1:0] load_lanes;
    logic [LEN_WIDTH-1:0]                       beat_cnt;
    logic [LEN_WIDTH-1:0]                       load_idx;
    logic                                       flush_pend;

    logic s_fire, m_fire, out_free, beat_full, emit_flush;
    logic load, load_last, len_hit, flush_arm;

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = enable && !flush_pend && ((lane_idx != LAST_LANE) || out_free);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign beat_full     = s_fire && (lane_idx == LAST_LANE);
    assign emit_flush    = flush_pend && out_free;
    assign load          = beat_full || emit_flush;

    // A flush only arms when something would actually be in the beat,
    // counting a sample accepted in the same cycle.
    assign flush_arm = flush && !flush_pend && !beat_full && ((lane_idx != '0) || s_fire);

    // Position of the beat being loaded within its packet: when the current
    // occupant drains in the same cycle, the counter has not caught up yet.
    always_comb begin
        load_idx = beat_cnt;
        if (m_fire) load_idx = m_axis_tlast ? '0 : beat_cnt + 1'b1;
    end

    assign len_hit   = (packet_len != '0) && (load_idx == packet_len - 1'b1);
    assign load_last = emit_flush || len_hit || (flush && beat_full);

    // Lanes not yet filled read as zero, so a flushed partial beat is padded.
    always_comb begin
        load_lanes = '0;
        for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
            if (s_fire && (lane_idx == lane_idx_t'(i)))
                load_lanes[i] = s_axis_tdata;
            else if (lane_idx_t'(i) < lane_idx)
                load_lanes[i] = pack_buf[i];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pack_buf <= '0;
        end else if (s_fire) begin
            for (int i = 0; i < SAMPLES_PER_BEAT; i++)
                if (lane_idx == lane_idx_t'(i)) pack_buf[i] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lane_idx   <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (emit_flush)  lane_idx <= '0;
            else if (s_fire) lane_idx <= beat_full ? '0 : lane_idx + 1'b1;

            if (emit_flush)     flush_pend <= 1'b0;
            else if (flush_arm) flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt     <= '0;
            packet_count <= '0;
        end else if (m_fire) begin
            beat_cnt <= m_axis_tlast ? '0 : beat_cnt + 1'b1;
            if (m_axis_tlast) packet_count <= packet_count + 32'd1;
        end
    end

    adc_stream_beat_reg #(
        .WIDTH(DATA_WIDTH * SAMPLES_PER_BEAT)
    ) u_beat_reg (
        .aclk      (aclk),
        .areset    (areset),
        .load      (load),
        .load_data (load_lanes),
        .load_last (load_last),
        .tready    (m_axis_tready),
        .tvalid    (m_axis_tvalid),
        .tdata     (m_axis_tdata),
        .tlast     (m_axis_tlast)
    );

endmodule
